// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
package arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Requester-side bus bundle: requests, data, and the arbiter's grant/mux outputs.
interface rr_bus_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 4
) ();
    logic [N-1:0]                   req;
    logic [N-1:0]                   last;
    logic [N*WIDTH-1:0]             d;
    logic [N-1:0]                   gnt;
    logic [arb_pkg::idx_w(N)-1:0]   sel;
    logic                           bus_en;
    logic [WIDTH-1:0]               y;

    modport slave  (input req, last, d, output gnt, sel, bus_en, y);
    modport master (output req, last, d, input gnt, sel, bus_en, y);
endinterface

// File: rtl/rr_bus_arbiter_pick.sv
// Rotated priority encoder: first asserted request at or above the pointer, wrapping mod N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    localparam int SW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic          o_any,
    output logic [SW-1:0] o_idx
);
    int            w_j;
    logic [SW-1:0] w_jidx;
    logic          w_found;

    always_comb begin
        w_j     = 0;
        w_jidx  = '0;
        w_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            w_jidx = SW'(w_j);
            if (!w_found && i_req[w_jidx]) begin
                w_found = 1'b1;
                o_idx   = w_jidx;
            end
        end
        o_any = w_found;
    end
endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin owner of a shared bus with a one-cycle turnaround between tenures.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 4,
    parameter int MAXHOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    rr_bus_arbiter_if.slave  bus
);
    localparam int SW = idx_w(N);
    localparam int CW = idx_w(MAXHOLD + 1);

    arb_state_t     r_state, w_state_nxt;
    logic [N-1:0]   r_gnt, w_gnt_nxt;
    logic [SW-1:0]  r_sel, w_sel_nxt;
    logic           r_bus_en, w_bus_en_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [SW-1:0]  r_ptr, w_ptr_nxt;

    logic           w_any;
    logic [SW-1:0]  w_idx;
    logic           w_release;
    logic [N-1:0][WIDTH-1:0] w_d;

    rr_pick #(.N(N)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // Only the current owner's req/last matter; everyone else waits for TURN.
    assign w_release = !bus.req[r_sel] || bus.last[r_sel] ||
                       (r_cnt == CW'(MAXHOLD - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_sel_nxt    = r_sel;
        w_bus_en_nxt = r_bus_en;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            IDLE, TURN: begin
                if (w_any) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = N'(1) << w_idx;
                    w_sel_nxt    = w_idx;
                    w_bus_en_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_bus_en_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    // sel keeps the old owner so the mux stays stable until the next grant.
                    w_state_nxt  = TURN;
                    w_gnt_nxt    = '0;
                    w_bus_en_nxt = 1'b0;
                    w_ptr_nxt    = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;
                end else begin
                    w_cnt_nxt    = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_gnt_nxt    = '0;
                w_bus_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_sel    <= '0;
            r_bus_en <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_sel    <= w_sel_nxt;
            r_bus_en <= w_bus_en_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign w_d        = bus.d;
    assign bus.gnt    = r_gnt;
    assign bus.sel    = r_sel;
    assign bus.bus_en = r_bus_en;
    assign bus.y      = r_bus_en ? w_d[r_sel] : '0;

    always @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(r_gnt));
            assert (r_bus_en == |r_gnt);
            assert (r_state != GRANT || r_gnt == (N'(1) << r_sel));
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed vector table, round-robin rotation sequence and random traffic against a tenure-level model.
module tb_rr_bus_arbiter;
    localparam int N = 4, W = 4, MH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rr_bus_arbiter_if #(.N(N), .WIDTH(W)) bus ();
    rr_bus_arbiter #(.N(N), .WIDTH(W), .MAXHOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: who owns the bus, for how many cycles, and who is favoured next.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic [15:0] d;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic        en;
        logic [3:0]  y;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rq, input int ptr);
        for (int k = 0; k < N; k++)
            if (rq[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic void model_edge(input logic rs, input logic [N-1:0] rq, input logic [N-1:0] lt);
        int w;
        if (rs) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (!rq[m_owner] || lt[m_owner] || m_held == MH) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            w = pick(rq, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_held = 0;
            end
        end
    endfunction

    // One clock: drive inputs, advance the model, then check the DUT after the edge.
    task automatic step(input logic rs, input logic [N-1:0] rq, input logic [N-1:0] lt,
                        input logic [N*W-1:0] dd);
        logic [N-1:0] eg;
        logic [W-1:0] ey;
        logic [W-1:0] dsel;
        reset = rs; bus.req = rq; bus.last = lt; bus.d = dd;
        @(posedge clk);
        model_edge(rs, rq, lt);
        #1;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ey = (m_owner >= 0) ? dd[m_owner*W +: W] : '0;
        chk("model_gnt", 32'(bus.gnt), 32'(eg));
        chk("model_sel", 32'(bus.sel), 32'(m_sel));
        chk("model_bus_en", 32'(bus.bus_en), 32'(m_owner >= 0));
        chk("model_y", 32'(bus.y), 32'(ey));
        chk("inv_onehot", 32'($onehot0(bus.gnt)), 32'(1));
        chk("inv_bus_en", 32'(bus.bus_en), 32'(|bus.gnt));
        dsel = dd[bus.sel*W +: W];
        if (bus.bus_en) chk("inv_y_owner", 32'(bus.y), 32'(dsel));
    endtask

    function automatic void add(input logic rs, input logic [3:0] rq, input logic [3:0] lt,
                                input logic [15:0] dd, input logic [3:0] g, input logic [1:0] s,
                                input logic e, input logic [3:0] y);
        vec_t v;
        v = '{rs, rq, lt, dd, g, s, e, y};
        vt.push_back(v);
    endfunction

    initial begin
        logic [3:0] eg;
        bus.req = '0; bus.last = '0; bus.d = '0;

        // Reset, then an idle bus.
        add(1, 4'h0, 4'h0, 16'h4321, 4'h0, 2'd0, 0, 4'h0);
        for (int i = 0; i < 5; i++) add(0, 4'h0, 4'h0, 16'h4321, 4'h0, 2'd0, 0, 4'h0);
        // Two requesters; owner 1 drops req, turnaround, then 3 takes over.
        for (int i = 0; i < 3; i++) add(0, 4'hA, 4'h0, 16'h4321, 4'h2, 2'd1, 1, 4'h2);
        add(0, 4'h8, 4'h0, 16'h4321, 4'h0, 2'd1, 0, 4'h0);
        add(0, 4'h8, 4'h0, 16'h4321, 4'h8, 2'd3, 1, 4'h4);
        add(0, 4'h0, 4'h0, 16'h4321, 4'h0, 2'd3, 0, 4'h0);
        add(0, 4'h0, 4'h0, 16'h4321, 4'h0, 2'd3, 0, 4'h0);
        // last on the second granted cycle gives exactly two cycles of data.
        add(0, 4'h4, 4'h0, 16'h0A00, 4'h4, 2'd2, 1, 4'hA);
        add(0, 4'h4, 4'h0, 16'h0A00, 4'h4, 2'd2, 1, 4'hA);
        add(0, 4'h4, 4'h4, 16'h0A00, 4'h0, 2'd2, 0, 4'h0);
        add(0, 4'h0, 4'h0, 16'h0A00, 4'h0, 2'd2, 0, 4'h0);
        // Reset in requester 1's third granted cycle; pointer back to 0 afterwards.
        for (int i = 0; i < 3; i++) add(0, 4'h2, 4'h0, 16'h4321, 4'h2, 2'd1, 1, 4'h2);
        add(1, 4'h3, 4'h0, 16'h4321, 4'h0, 2'd0, 0, 4'h0);
        add(0, 4'h3, 4'h0, 16'h4321, 4'h1, 2'd0, 1, 4'h1);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].rst, vt[i].req, vt[i].last, vt[i].d);
            chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vt[i].gnt));
            chk($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vt[i].sel));
            chk($sformatf("vec%0d_bus_en", i), 32'(bus.bus_en), 32'(vt[i].en));
            chk($sformatf("vec%0d_y", i), 32'(bus.y), 32'(vt[i].y));
        end

        // All requesting: 8-cycle tenures rotating 0,1,2,3,0 with one dead cycle between.
        step(1, 4'h0, 4'h0, 16'h4321);
        for (int k = 0; k < 45; k++) begin
            step(0, 4'hF, 4'h0, 16'h4321);
            eg = ((k % 9) < 8) ? (4'h1 << ((k / 9) % 4)) : 4'h0;
            chk($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(eg));
        end

        // Random traffic with rare last pulses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  rq, lt;
            logic [15:0] dd;
            logic        rs;
            rq = 4'($urandom);
            lt = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            dd = 16'($urandom);
            rs = ($urandom_range(0, 199) == 0);
            step(rs, rq, lt, dd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
